// File: rtl/monitor_contador_pkg.sv
// Shared definitions for the bounce-counter monitor: FSM state encoding and
// default widths used by the top and the event counters.
package monitor_contador_pkg;

    // state  | meaning
    // BUSCA0 | nothing stored yet, waiting for a first sample
    // BUSCA1 | one sample held in ult, trying to infer direction
    // SOBE   | locked, sequence is counting up
    // DESCE  | locked, sequence is counting down
    typedef enum logic [1:0] {
        BUSCA0 = 2'd0,
        BUSCA1 = 2'd1,
        SOBE   = 2'd2,
        DESCE  = 2'd3
    } estado_t;

    localparam int LARGURA_PADRAO  = 4;
    localparam int LARG_CNT_PADRAO = 8;

endpackage

// File: rtl/monitor_contador_contador_saturado.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module contador_saturado
    import monitor_contador_pkg::*;
#(
    parameter int LARGURA = LARG_CNT_PADRAO
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               incremento,
    output logic [LARGURA-1:0] valor
);

    localparam logic [LARGURA-1:0] UM = LARGURA'(1);

    // Count enabled events, holding at the maximum once reached.
    always_ff @(posedge clk) begin
        if (!reset) begin
            valor <= '0;
        end else if (incremento && (valor != '1)) begin
            valor <= valor + UM;
        end
    end

endmodule

// File: rtl/monitor_contador.sv
// Monitor for an up/down bounce counter 0..MAXV,MAXV..0,0,...
// Locks onto the sequence, flags peaks, valleys and prediction errors, and
// keeps saturating counts of complete periods and of errors.
//
// state  | meaning
// BUSCA0 | no stored sample
// BUSCA1 | one stored sample (ult), direction not yet known
// SOBE   | tracking, ascending
// DESCE  | tracking, descending
module monitor_contador
    import monitor_contador_pkg::*;
#(
    parameter int LARGURA  = LARGURA_PADRAO,
    parameter int LARG_CNT = LARG_CNT_PADRAO
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                valido,
    input  logic [LARGURA-1:0]  amostra,
    output logic                sincronizado,
    output logic                direcao,
    output logic                pico,
    output logic                vale,
    output logic                erro,
    output logic [LARG_CNT-1:0] n_ciclos,
    output logic [LARG_CNT-1:0] n_erros
);

    localparam logic [LARGURA-1:0] MAXV = '1;
    localparam logic [LARGURA-1:0] UM   = LARGURA'(1);

    estado_t            estado;
    logic [LARGURA-1:0] ult;
    logic [LARGURA-1:0] predicao;
    logic               confere;
    logic               sobe_ok;
    logic               desce_ok;
    logic               inc_ciclos;
    logic               inc_erros;

    // Expected next sample; the ends never wrap, they repeat (dwell).
    always_comb begin
        predicao   = ult;
        sobe_ok    = ((amostra == ult + UM) && (ult != MAXV)) ||
                     ((amostra == '0) && (ult == '0));
        desce_ok   = ((amostra == ult - UM) && (ult != '0)) ||
                     ((amostra == MAXV) && (ult == MAXV));
        case (estado)
            SOBE:    predicao = (ult == MAXV) ? MAXV : ult + UM;
            DESCE:   predicao = (ult == '0)   ? '0   : ult - UM;
            default: predicao = ult;
        endcase
        confere    = (amostra == predicao);
        inc_erros  = valido && ((estado == SOBE) || (estado == DESCE)) && !confere;
        inc_ciclos = valido && (estado == DESCE) && (ult == '0) && confere;
    end

    // Sequence tracking FSM with registered event pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            estado <= BUSCA0;
            ult    <= '0;
            pico   <= 1'b0;
            vale   <= 1'b0;
            erro   <= 1'b0;
        end else begin
            pico <= 1'b0;
            vale <= 1'b0;
            erro <= 1'b0;
            if (valido) begin
                ult <= amostra;
                case (estado)
                    BUSCA0: estado <= BUSCA1;
                    BUSCA1: begin
                        if (sobe_ok) begin
                            estado <= SOBE;
                        end else if (desce_ok) begin
                            estado <= DESCE;
                        end
                    end
                    SOBE: begin
                        if (!confere) begin
                            erro   <= 1'b1;
                            estado <= BUSCA1;
                        end else if (ult == MAXV) begin
                            pico   <= 1'b1;
                            estado <= DESCE;
                        end
                    end
                    DESCE: begin
                        if (!confere) begin
                            erro   <= 1'b1;
                            estado <= BUSCA1;
                        end else if (ult == '0) begin
                            vale   <= 1'b1;
                            estado <= SOBE;
                        end
                    end
                    default: estado <= BUSCA0;
                endcase
            end
        end
    end

    // Status flags are straight decodes of the state register.
    assign sincronizado = (estado == SOBE) || (estado == DESCE);
    assign direcao      = (estado == DESCE);

    contador_saturado #(.LARGURA(LARG_CNT)) u_ciclos (
        .clk        (clk),
        .reset      (reset),
        .incremento (inc_ciclos),
        .valor      (n_ciclos)
    );

    contador_saturado #(.LARGURA(LARG_CNT)) u_erros (
        .clk        (clk),
        .reset      (reset),
        .incremento (inc_erros),
        .valor      (n_erros)
    );

endmodule

// File: tb/tb_monitor_contador.sv
// Directed bench for monitor_contador (LARGURA=4, LARG_CNT=8).
module tb_monitor_contador;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valido = 1'b0;
    logic [3:0] amostra = 4'd0;
    logic       sincronizado;
    logic       direcao;
    logic       pico;
    logic       vale;
    logic       erro;
    logic [7:0] n_ciclos;
    logic [7:0] n_erros;

    int total = 0;
    int bad = 0;

    monitor_contador #(.LARGURA(4), .LARG_CNT(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .valido       (valido),
        .amostra      (amostra),
        .sincronizado (sincronizado),
        .direcao      (direcao),
        .pico         (pico),
        .vale         (vale),
        .erro         (erro),
        .n_ciclos     (n_ciclos),
        .n_erros      (n_erros)
    );

    always #5 clk = ~clk;

    // Position k of the ideal sequence: 0..15,15..0 repeating every 32.
    function automatic logic [3:0] seq(input int k);
        int m;
        m = k % 32;
        if (m < 16) return 4'(m);
        return 4'(31 - m);
    endfunction

    task automatic passo(input logic v, input logic [3:0] a);
        valido  = v;
        amostra = a;
        @(posedge clk);
        #1;
    endtask

    task automatic aplica_reset();
        reset   = 1'b0;
        valido  = 1'b1;
        amostra = 4'd3;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        aplica_reset();
        total++;
        if ({sincronizado, direcao, pico, vale, erro, n_ciclos, n_erros} !== 21'd0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {sincronizado, direcao, pico, vale, erro, n_ciclos, n_erros});
        end
    endtask

    task automatic test_subida();
        aplica_reset();
        passo(1'b1, 4'd0);
        total++;
        if (sincronizado !== 1'b0) begin bad++; $display("FAIL subida_sinc0 got=%0b exp=0", sincronizado); end
        passo(1'b1, 4'd1);
        total++;
        if ({sincronizado, direcao} !== 2'b10) begin bad++; $display("FAIL subida_sinc1 got=%b exp=10", {sincronizado, direcao}); end
        passo(1'b1, 4'd2);
        total++;
        if ({sincronizado, direcao, erro, n_erros} !== {3'b100, 8'd0}) begin
            bad++; $display("FAIL subida_sinc2 got=%b exp=10000000000", {sincronizado, direcao, erro, n_erros});
        end
    endtask

    task automatic test_periodo();
        int n_pico, n_vale, i_pico, i_vale;
        n_pico = 0; n_vale = 0; i_pico = -1; i_vale = -1;
        aplica_reset();
        for (int i = 0; i <= 32; i++) begin
            passo(1'b1, seq(i));
            if (pico) begin n_pico++; i_pico = i; end
            if (vale) begin n_vale++; i_vale = i; end
            if (i == 20) begin
                total++;
                if ({sincronizado, direcao} !== 2'b11) begin bad++; $display("FAIL periodo_desce got=%b exp=11", {sincronizado, direcao}); end
            end
        end
        total++;
        if (n_pico !== 1 || i_pico !== 16) begin bad++; $display("FAIL periodo_pico got=%0d@%0d exp=1@16", n_pico, i_pico); end
        total++;
        if (n_vale !== 1 || i_vale !== 32) begin bad++; $display("FAIL periodo_vale got=%0d@%0d exp=1@32", n_vale, i_vale); end
        total++;
        if (n_ciclos !== 8'd1 || n_erros !== 8'd0) begin bad++; $display("FAIL periodo_contagem got=%0d/%0d exp=1/0", n_ciclos, n_erros); end
        total++;
        if ({sincronizado, direcao} !== 2'b10) begin bad++; $display("FAIL periodo_fim got=%b exp=10", {sincronizado, direcao}); end
    endtask

    task automatic test_erro();
        aplica_reset();
        for (int i = 0; i <= 5; i++) passo(1'b1, 4'(i));
        passo(1'b1, 4'd9);
        total++;
        if ({erro, sincronizado, n_erros} !== {2'b10, 8'd1}) begin
            bad++; $display("FAIL erro_pulso got=%b/%b/%0d exp=1/0/1", erro, sincronizado, n_erros);
        end
        passo(1'b1, 4'd10);
        total++;
        if ({erro, sincronizado, direcao, n_erros} !== {3'b010, 8'd1}) begin
            bad++; $display("FAIL erro_resync got=%b/%b/%b/%0d exp=0/1/0/1", erro, sincronizado, direcao, n_erros);
        end
    endtask

    task automatic test_lacunas();
        int n_pico, n_vale, i_pico, i_vale, espurios;
        logic s_antes;
        n_pico = 0; n_vale = 0; i_pico = -1; i_vale = -1; espurios = 0;
        aplica_reset();
        for (int i = 0; i <= 32; i++) begin
            passo(1'b1, seq(i));
            if (pico) begin n_pico++; i_pico = i; end
            if (vale) begin n_vale++; i_vale = i; end
            s_antes = sincronizado;
            passo(1'b0, 4'(i * 7 + 3));
            if (pico || vale || erro || sincronizado !== s_antes) espurios++;
        end
        total++;
        if (espurios !== 0) begin bad++; $display("FAIL lacunas_espurios got=%0d exp=0", espurios); end
        total++;
        if (n_pico !== 1 || i_pico !== 16 || n_vale !== 1 || i_vale !== 32) begin
            bad++; $display("FAIL lacunas_eventos got=%0d@%0d/%0d@%0d exp=1@16/1@32", n_pico, i_pico, n_vale, i_vale);
        end
        total++;
        if (n_ciclos !== 8'd1 || n_erros !== 8'd0) begin bad++; $display("FAIL lacunas_contagem got=%0d/%0d exp=1/0", n_ciclos, n_erros); end
    endtask

    task automatic test_meio();
        int n_pico;
        n_pico = 0;
        aplica_reset();
        passo(1'b1, 4'd15);
        total++;
        if (sincronizado !== 1'b0) begin bad++; $display("FAIL meio_primeiro got=%0b exp=0", sincronizado); end
        passo(1'b1, 4'd15);
        total++;
        if ({sincronizado, direcao, pico} !== 3'b110) begin bad++; $display("FAIL meio_aquisicao got=%b exp=110", {sincronizado, direcao, pico}); end
        for (int k = 17; k <= 32; k++) begin
            passo(1'b1, seq(k));
            if (pico) n_pico++;
        end
        total++;
        if (n_ciclos !== 8'd1 || vale !== 1'b1 || n_pico !== 0) begin
            bad++; $display("FAIL meio_vale got=%0d/%b/%0d exp=1/1/0", n_ciclos, vale, n_pico);
        end
        for (int k = 33; k <= 64; k++) begin
            passo(1'b1, seq(k));
            if (pico) n_pico++;
        end
        total++;
        if (n_ciclos !== 8'd2 || n_erros !== 8'd0 || n_pico !== 1) begin
            bad++; $display("FAIL meio_proximo got=%0d/%0d/%0d exp=2/0/1", n_ciclos, n_erros, n_pico);
        end
    endtask

    task automatic test_saturacao();
        aplica_reset();
        passo(1'b1, 4'd0);
        for (int k = 1; k <= 300 * 32; k++) begin
            passo(1'b1, seq(k));
            if (k == 100 * 32) begin
                total++;
                if (n_ciclos !== 8'd100) begin bad++; $display("FAIL sat_100 got=%0d exp=100", n_ciclos); end
            end
        end
        total++;
        if (n_ciclos !== 8'd255 || n_erros !== 8'd0) begin bad++; $display("FAIL sat_final got=%0d/%0d exp=255/0", n_ciclos, n_erros); end
        for (int k = 1; k <= 7; k++) passo(1'b1, seq(k));
        aplica_reset();
        total++;
        if ({sincronizado, direcao, pico, vale, erro, n_ciclos, n_erros} !== 21'd0) begin
            bad++; $display("FAIL sat_reset got=%h exp=0", {sincronizado, direcao, pico, vale, erro, n_ciclos, n_erros});
        end
        passo(1'b1, 4'd8);
        total++;
        if (sincronizado !== 1'b0) begin bad++; $display("FAIL sat_reacq1 got=%0b exp=0", sincronizado); end
        passo(1'b1, 4'd9);
        total++;
        if ({sincronizado, direcao, n_ciclos} !== {2'b10, 8'd0}) begin
            bad++; $display("FAIL sat_reacq2 got=%b/%b/%0d exp=1/0/0", sincronizado, direcao, n_ciclos);
        end
    endtask

    initial begin
        reset = 1'b0;
        #2;
        test_reset();
        test_subida();
        test_periodo();
        test_erro();
        test_lacunas();
        test_meio();
        test_saturacao();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/monitor_contador.md
MONITOR_CONTADOR -- requirements
Module: monitor_contador

Interface
REQ-001 The block SHALL have parameter LARGURA, default 4, giving the sample width; the maximum value is MAXV = 2^LARGURA-1.
REQ-002 The block SHALL have parameter LARG_CNT, default 8, giving the width of both event counters.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port valido  input  1  qualifies amostra in the current cycle.
REQ-006 The block SHALL have port amostra  input  LARGURA  sampled value from an up/down bounce counter.
REQ-007 The block SHALL have port sincronizado  output  1  high while tracking a valid bounce sequence.
REQ-008 The block SHALL have port direcao  output  1  0 = ascending, 1 = descending; meaningful only when sincronizado=1.
REQ-009 The block SHALL have port pico  output  1  one-cycle pulse when the top dwell (MAXV twice) is accepted.
REQ-010 The block SHALL have port vale  output  1  one-cycle pulse when the bottom dwell (0 twice) is accepted.
REQ-011 The block SHALL have port erro  output  1  one-cycle pulse when a sample mismatches the prediction.
REQ-012 The block SHALL have port n_ciclos  output  LARG_CNT  number of complete periods (accepted vale events); saturating.
REQ-013 The block SHALL have port n_erros  output  LARG_CNT  number of erro events; saturating.

Function
REQ-014 The block SHALL track the sequence 0,1,…,MAXV,MAXV,MAXV-1,…,0,0,1,… (period 2*MAXV+2, i.e. 32 for LARGURA=4).
REQ-015 The block SHALL use the FSM states BUSCA0 (no stored sample), BUSCA1 (one stored sample, ult), SOBE and DESCE.
REQ-016 In BUSCA0, a valid sample SHALL store ult=amostra and move to BUSCA1.
REQ-017 In BUSCA1, a valid sample s SHALL move to SOBE if s=ult+1 or s=ult=0, and to DESCE if s=ult-1 or s=ult=MAXV; otherwise it SHALL stay in BUSCA1; in all cases ult=s.
REQ-018 In SOBE, the prediction SHALL be ult+1 if ult<MAXV, and SHALL be MAXV if ult=MAXV; a match on the MAXV dwell SHALL move to DESCE and pulse pico.
REQ-019 In DESCE, the prediction SHALL be ult-1 if ult>0, and SHALL be 0 if ult=0; a match on the 0 dwell SHALL move to SOBE, pulse vale and increment n_ciclos.
REQ-020 In SOBE or DESCE, a valid sample differing from the prediction SHALL pulse erro, increment n_erros, set ult=amostra and move to BUSCA1.
REQ-021 Acquisition transitions out of BUSCA1 SHALL NOT generate pico or vale pulses and SHALL NOT increment n_ciclos.
REQ-022 All outputs SHALL be registered, with one-cycle latency from the valid sample to its effect.
REQ-023 sincronizado SHALL be 1 exactly when the state is SOBE or DESCE.
REQ-024 direcao SHALL be 1 exactly in DESCE.
REQ-025 When valido=0, all state, ult and counters SHALL hold, and pico, vale and erro SHALL be 0.
REQ-026 pico, vale and erro SHALL be mutually exclusive in any cycle.
REQ-027 n_ciclos and n_erros SHALL saturate at 2^LARG_CNT-1 and never wrap.
REQ-028 Arithmetic on ult±1 SHALL be done at LARGURA width, and no wrapped prediction SHALL be used: ult=MAXV in SOBE and ult=0 in DESCE always take the dwell rule.

Reset
REQ-029 When reset=0 at a clock edge, the state SHALL become BUSCA0 and ult, every output and both counters SHALL become 0, overriding valido.
REQ-030 Reset asserted mid-sequence SHALL discard tracking, and reacquisition after release SHALL require two valid samples.

Structure
REQ-031 A shared package SHALL hold the state enum (BUSCA0, BUSCA1, SOBE, DESCE) and the default parameter constants.
REQ-032 A single sub-module contador_saturado (parameter width, increment enable, synchronous active-low reset) SHALL be instantiated twice, once for n_ciclos and once for n_erros.

Verification
REQ-033 Bench scenario: reset, then 0,1,2 valid -> sincronizado=1 after the second sample, direcao=0, no erro.
REQ-034 Bench scenario: full period 0..15,15,14..0,0 -> exactly one pico (cycle after the second 15), one vale, n_ciclos=1, n_erros=0.
REQ-035 Bench scenario: in sync with ult=5 ascending, sample 9 -> erro pulse, n_erros=1, sincronizado=0; then 10 -> resync in SOBE.
REQ-036 Bench scenario: valido toggled low every other cycle over a period -> results identical to the gapless run, with no spurious pulses while low.
REQ-037 Bench scenario: start mid-sequence at 15,15,14 -> DESCE acquired after the second 15 with no pico; the next period counts normally.
REQ-038 Bench scenario: 300 periods with LARG_CNT=8 -> n_ciclos holds at 255; reset=0 mid-period -> all outputs 0 on the next cycle.
